// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM stage: FSM state encoding, field widths and the
// MEM/WB pipeline register layout.
package mem_access_unit_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic [REG_W-1:0]  write_register;
      logic [WORD_W-1:0] alu_result;
      logic [WORD_W-1:0] read_data;
   } memwb_t;

endpackage

// File: rtl/mem_access_unit_memwb_reg.sv
// MEM/WB pipeline register; a bubble loads all-zero fields (no write-back).
import mem_access_unit_pkg::*;

module memwb_reg (
   input  logic   clk,
   input  logic   rst,
   input  logic   bubble_i,
   input  memwb_t d_i,
   output memwb_t q_o
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_o <= '0;
      end else if (bubble_i) begin
         q_o <= '0;
      end else begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs word loads/stores on a handshaked data-memory port, stalls
// upstream while an access is outstanding and owns the MEM/WB register.
import mem_access_unit_pkg::*;

module mem_access_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] alu_result,
   input  logic [WORD_W-1:0] store_data,
   input  logic [REG_W-1:0]  write_register,
   input  logic [REG_W-1:0]  rt,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_to_reg,
   input  logic              wb_reg_write,
   input  logic [REG_W-1:0]  wb_write_register,
   input  logic [WORD_W-1:0] wb_write_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [WORD_W-1:0] dmem_addr,
   output logic [WORD_W-1:0] dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [WORD_W-1:0] dmem_rdata,
   output logic              stall,
   output logic              misalign,
   output logic              bus_err,
   output logic              memwb_reg_write,
   output logic              memwb_mem_to_reg,
   output logic [REG_W-1:0]  memwb_write_register,
   output logic [WORD_W-1:0] memwb_alu_result,
   output logic [WORD_W-1:0] memwb_read_data
);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0] rdata_q;
   logic [REG_W-1:0]  wreg_q;
   logic              we_q;
   logic              regw_q;
   logic              m2r_q;
   logic              err_q;

   logic              mem_op;
   logic              aligned;
   logic              fwd;
   logic [WORD_W-1:0] eff_wdata;
   logic              timeout;
   logic              in_idle;
   logic              busy;
   logic              bubble;
   memwb_t            memwb_d;
   memwb_t            memwb_q;

   assign mem_op    = mem_read | mem_write;
   assign aligned   = (alu_result[1:0] == 2'b00);
   assign fwd       = wb_reg_write & (wb_write_register == rt) & (rt != '0);
   assign eff_wdata = fwd ? wb_write_data : store_data;
   // Fires on the cycle whose increment would reach TIMEOUT-1.
   assign timeout   = (cnt_q == CNT_W'(TIMEOUT - 2));
   assign in_idle   = (state_q == S_IDLE);
   assign busy      = (state_q == S_REQ) || (state_q == S_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wreg_q  <= '0;
         we_q    <= 1'b0;
         regw_q  <= 1'b0;
         m2r_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mem_op && aligned) begin
                  state_q <= S_REQ;
                  cnt_q   <= '0;
                  addr_q  <= alu_result;
                  wdata_q <= eff_wdata;
                  we_q    <= mem_write;
                  wreg_q  <= write_register;
                  regw_q  <= reg_write;
                  m2r_q   <= mem_to_reg;
                  rdata_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            S_REQ: begin
               cnt_q <= cnt_q + 1'b1;
               if (timeout) begin
                  err_q   <= 1'b1;
                  state_q <= S_DONE;
               end else if (dmem_gnt) begin
                  state_q <= we_q ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (dmem_rvalid) begin
                  rdata_q <= dmem_rdata;
                  state_q <= S_DONE;
               end else if (timeout) begin
                  err_q   <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign dmem_req   = (state_q == S_REQ) && !timeout;
   assign dmem_we    = dmem_req & we_q;
   assign dmem_addr  = dmem_req ? addr_q  : '0;
   assign dmem_wdata = dmem_req ? wdata_q : '0;
   assign bus_err    = timeout && ((state_q == S_REQ) ||
                                   ((state_q == S_WAIT) && !dmem_rvalid));
   assign misalign   = !rst && in_idle && mem_op && !aligned;
   assign stall      = !rst && (busy || (in_idle && mem_op && aligned));

   always_comb begin
      memwb_d = '0;
      bubble  = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (!(mem_op && aligned)) begin
               bubble                 = 1'b0;
               memwb_d.reg_write      = reg_write & !mem_op;
               memwb_d.mem_to_reg     = mem_to_reg;
               memwb_d.write_register = write_register;
               memwb_d.alu_result     = alu_result;
            end
         end
         S_DONE: begin
            bubble                 = 1'b0;
            memwb_d.reg_write      = regw_q & !err_q;
            memwb_d.mem_to_reg     = m2r_q;
            memwb_d.write_register = wreg_q;
            memwb_d.alu_result     = addr_q;
            memwb_d.read_data      = (err_q || we_q) ? '0 : rdata_q;
         end
         default: begin
            bubble = 1'b1;
         end
      endcase
   end

   memwb_reg u_memwb (
      .clk      (clk),
      .rst      (rst),
      .bubble_i (bubble),
      .d_i      (memwb_d),
      .q_o      (memwb_q)
   );

   assign memwb_reg_write      = memwb_q.reg_write;
   assign memwb_mem_to_reg     = memwb_q.mem_to_reg;
   assign memwb_write_register = memwb_q.write_register;
   assign memwb_alu_result     = memwb_q.alu_result;
   assign memwb_read_data      = memwb_q.read_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a random memory responder, an
// in-order MEM/WB result queue and a request queue checked at each grant.
module tb_mem_access_unit;

   typedef struct packed {
      logic        rw, m2r;
      logic [4:0]  wr;
      logic [31:0] alu, rd;
   } mw_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr, wd;
   } rq_t;

   typedef struct {
      logic [31:0] alu, sd, wbwd;
      logic [4:0]  wr, rt, wbwr;
      logic        rw, mr, mw, m2r, wbrw;
   } instr_t;

   logic        clk, rst;
   logic [31:0] alu_result, store_data, wb_write_data, dmem_rdata;
   logic [4:0]  write_register, rt, wb_write_register;
   logic        reg_write, mem_read, mem_write, mem_to_reg, wb_reg_write;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        stall, misalign, bus_err;
   logic        memwb_reg_write, memwb_mem_to_reg;
   logic [4:0]  memwb_write_register;
   logic [31:0] memwb_alu_result, memwb_read_data;

   int unsigned checks = 0;
   int unsigned failures = 0;

   mw_t         exp_q[$];
   rq_t         req_q[$];
   logic [31:0] ref_mem [64];
   logic [31:0] mem     [64];
   bit          active = 0;
   bit          auto_resp = 1;
   bit          no_gnt = 0;
   int          fix_g = -1;
   int          fix_r = -1;

   mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .alu_result(alu_result), .store_data(store_data),
      .write_register(write_register), .rt(rt),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg),
      .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register),
      .wb_write_data(wb_write_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata),
      .stall(stall), .misalign(misalign), .bus_err(bus_err),
      .memwb_reg_write(memwb_reg_write), .memwb_mem_to_reg(memwb_mem_to_reg),
      .memwb_write_register(memwb_write_register),
      .memwb_alu_result(memwb_alu_result), .memwb_read_data(memwb_read_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Memory responder: random grant/rvalid latency, checks each granted request.
   initial begin
      int  gcnt, rcnt;
      bit  rpend;
      rq_t r;
      logic [31:0] rd;
      gcnt = -1; rcnt = 0; rpend = 0; rd = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!auto_resp) continue;
         dmem_gnt = 1'b0;
         dmem_rvalid = 1'b0;
         if (rst) begin
            gcnt = -1; rpend = 0;
            continue;
         end
         if (rpend) begin
            if (rcnt == 0) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = rd;
               rpend = 0;
            end else begin
               rcnt--;
            end
         end else if (dmem_req && !no_gnt) begin
            if (gcnt < 0) gcnt = (fix_g >= 0) ? fix_g : int'($urandom_range(0, 3));
            if (gcnt == 0) begin
               dmem_gnt = 1'b1;
               gcnt = -1;
               if (req_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL req_unexpected: got request addr=%0h, required none", dmem_addr);
               end else begin
                  r = req_q.pop_front();
                  chk("req_addr", dmem_addr, r.addr);
                  chk("req_we", dmem_we, r.we);
                  if (r.we) chk("req_wdata", dmem_wdata, r.wd);
               end
               if (dmem_we) begin
                  mem[dmem_addr[7:2]] = dmem_wdata;
               end else begin
                  rd = mem[dmem_addr[7:2]];
                  rpend = 1;
                  rcnt = (fix_r >= 0) ? fix_r : int'($urandom_range(0, 3));
               end
            end else begin
               gcnt--;
            end
         end
      end
   end

   // Monitor: one MEM/WB result per edge on which the stage was not stalling.
   initial begin
      bit  pend;
      mw_t e;
      pend = 0;
      forever begin
         @(negedge clk);
         if (pend) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL memwb_unexpected: got result alu=%0h, required none", memwb_alu_result);
            end else begin
               e = exp_q.pop_front();
               chk("memwb", {memwb_reg_write, memwb_mem_to_reg, memwb_write_register,
                             memwb_alu_result, memwb_read_data}, e);
            end
         end
         pend = active && !rst && !stall;
      end
   end

   function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] sd,
                                 input logic [4:0] wr, input logic [4:0] rtv,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic m2r);
      instr_t i;
      i.alu = alu; i.sd = sd; i.wr = wr; i.rt = rtv;
      i.rw = rw; i.mr = mr; i.mw = mw; i.m2r = m2r;
      i.wbrw = 1'b0; i.wbwr = '0; i.wbwd = '0;
      return i;
   endfunction

   // Presents one instruction on EX/MEM until the stage accepts it.
   task automatic issue(input instr_t in, input bit to, output int n_stall,
                        output int n_mis, output int n_berr, output int berr_at,
                        output bit req_seen);
      mw_t         e;
      logic [31:0] wd;
      bit          mop, al, st, done;
      #1;
      alu_result = in.alu; store_data = in.sd; write_register = in.wr; rt = in.rt;
      reg_write = in.rw; mem_read = in.mr; mem_write = in.mw; mem_to_reg = in.m2r;
      wb_reg_write = in.wbrw; wb_write_register = in.wbwr; wb_write_data = in.wbwd;
      mop = in.mr | in.mw;
      al  = (in.alu[1:0] == 2'b00);
      wd  = (in.wbrw && in.wbwr == in.rt && in.rt != 0) ? in.wbwd : in.sd;
      e = '{rw: in.rw, m2r: in.m2r, wr: in.wr, alu: in.alu, rd: '0};
      if (mop && (!al || to)) begin
         e.rw = 1'b0;
      end else if (mop && in.mw) begin
         ref_mem[in.alu[7:2]] = wd;
         req_q.push_back('{we: 1'b1, addr: in.alu, wd: wd});
      end else if (mop) begin
         e.rd = ref_mem[in.alu[7:2]];
         req_q.push_back('{we: 1'b0, addr: in.alu, wd: '0});
      end
      exp_q.push_back(e);
      active = 1;
      n_stall = 0; n_mis = 0; n_berr = 0; berr_at = 0; req_seen = 0; done = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         st = stall;
         if (st) n_stall++;
         if (bus_err) begin
            n_berr++;
            berr_at = n_stall;
         end
         if (misalign) n_mis++;
         if (dmem_req) req_seen = 1;
         chk("misalign_level", misalign, mop && !al);
         @(posedge clk);
         if (!st) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL retire_bound: got no retire in 200 cycles, required retire");
      end
      active = 0;
   endtask

   initial begin
      instr_t i;
      int ns, nm, nb, ba;
      bit rs;
      int kind;
      logic [5:0] idx;

      for (int k = 0; k < 64; k++) begin
         ref_mem[k] = 32'hC0DE_0000 | k;
         mem[k]     = 32'hC0DE_0000 | k;
      end

      rst = 1'b1;
      alu_result = 32'h40; store_data = 32'h5; write_register = 5'd3; rt = 5'd2;
      reg_write = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
      wb_reg_write = 1'b0; wb_write_register = '0; wb_write_data = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, misalign, bus_err,
                            memwb_reg_write, memwb_mem_to_reg, memwb_write_register,
                            memwb_alu_result, memwb_read_data}, '0);
      reg_write = 1'b0; mem_read = 1'b0; mem_to_reg = 1'b0; alu_result = '0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);

      // ALU op
      issue(mk(32'h1234, 32'h0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), 0, ns, nm, nb, ba, rs);
      chk("alu_stall", ns, 0);
      chk("alu_noreq", rs, 0);

      // Load at 0x40: two REQ cycles, rvalid one cycle after gnt
      ref_mem[16] = 32'hDEAD_BEEF; mem[16] = 32'hDEAD_BEEF;
      fix_g = 1; fix_r = 0;
      issue(mk(32'h40, 32'h0, 5'd4, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1), 0, ns, nm, nb, ba, rs);
      chk("load_stall", ns, 4);

      // Store with forwarding from WB, then with rt=0 (no forwarding)
      fix_g = 0;
      i = mk(32'h20, 32'h11, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      i.wbrw = 1'b1; i.wbwr = 5'd7; i.wbwd = 32'h99;
      issue(i, 0, ns, nm, nb, ba, rs);
      chk("store_stall", ns, 2);
      i.rt = 5'd0; i.wbwr = 5'd0; i.alu = 32'h24;
      issue(i, 0, ns, nm, nb, ba, rs);
      chk("store_rt0_stall", ns, 2);

      // Misaligned load
      issue(mk(32'h42, 32'h0, 5'd6, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1), 0, ns, nm, nb, ba, rs);
      chk("misalign_pulses", nm, 1);
      chk("misalign_noreq", rs, 0);
      chk("misalign_stall", ns, 0);

      // Load never granted: bus error
      no_gnt = 1;
      issue(mk(32'h44, 32'h0, 5'd9, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1), 1, ns, nm, nb, ba, rs);
      chk("timeout_stall", ns, 16);
      chk("timeout_berr_count", nb, 1);
      chk("timeout_berr_at", ba, 16);
      no_gnt = 0; fix_g = -1; fix_r = -1;

      // Randomized mix
      for (int n = 0; n < 200; n++) begin
         kind = int'($urandom_range(0, 3));
         idx  = 6'($urandom_range(0, 63));
         i = mk($urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         i.wbrw = 1'($urandom_range(0, 1));
         i.wbwr = 5'($urandom_range(0, 7));
         i.wbwd = $urandom;
         if (kind == 1) begin
            i.alu = {24'h0, idx, 2'b00}; i.mr = 1'b1;
         end else if (kind == 2) begin
            i.alu = {24'h0, idx, 2'b00}; i.mw = 1'b1; i.mr = 1'($urandom_range(0, 1));
         end else if (kind == 3) begin
            i.alu = {24'h0, idx, 2'($urandom_range(1, 3))};
            if ($urandom_range(0, 1) == 1) i.mr = 1'b1;
            else i.mw = 1'b1;
         end
         issue(i, 0, ns, nm, nb, ba, rs);
      end

      // Reset while waiting for load data
      auto_resp = 0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      #1;
      alu_result = 32'h80; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
      mem_to_reg = 1'b1; write_register = 5'd3; wb_reg_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req_before", dmem_req, 1);
      dmem_gnt = 1'b1;
      @(posedge clk);
      #1 dmem_gnt = 1'b0;
      @(negedge clk);
      chk("rst_wait_stall", {stall, dmem_req}, 2'b10);
      #2 rst = 1'b1;
      #1;
      chk("rst_immediate", {stall, dmem_req, memwb_reg_write, memwb_mem_to_reg,
                            memwb_write_register, memwb_alu_result, memwb_read_data}, '0);
      @(posedge clk);
      #1;
      alu_result = '0; mem_read = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
      write_register = '0;
      @(negedge clk);
      rst = 1'b0;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
      @(posedge clk);
      #1 dmem_rvalid = 1'b0;
      @(negedge clk);
      chk("late_rvalid_ignored", {stall, dmem_req, memwb_reg_write, memwb_read_data}, '0);
      @(negedge clk);
      chk("late_rvalid_idle", {stall, memwb_reg_write, memwb_mem_to_reg, memwb_read_data}, '0);

      chk("exp_q_drained", exp_q.size(), 0);
      chk("req_q_drained", req_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register in the 5-stage MIPS core.
- Takes the EX/MEM control and data fields and runs word loads/stores on a handshaked data-memory port with variable latency.
- Stalls the upstream pipeline while an access is outstanding and owns the MEM/WB register feeding write-back.
- Forwards WB data onto the store-data path when Rt matches the WB destination.

Parameters:
- TIMEOUT, 16, max cycles in REQ+WAIT before aborting with bus error (≥2).
- CNT_W, 5, width of timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_result  in  32  EX/MEM address / ALU value
- store_data  in  32  EX/MEM register-file read data for stores
- write_register  in  5  EX/MEM destination register
- rt  in  5  EX/MEM Rt index
- reg_write, mem_read, mem_write, mem_to_reg  in  1 each  EX/MEM control
- wb_reg_write  in  1  WB-stage write enable
- wb_write_register  in  5  WB-stage destination
- wb_write_data  in  32  WB-stage result
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- misalign  out  1  one-cycle pulse: misaligned access dropped
- bus_err  out  1  one-cycle pulse: access timed out
- memwb_reg_write, memwb_mem_to_reg  out  1 each  MEM/WB control
- memwb_write_register  out  5
- memwb_alu_result, memwb_read_data  out  32

Behaviour:
- Reset: FSM→IDLE; counter and latches cleared; every output 0, including dmem_req immediately (asynchronous).
- mem_op = mem_read|mem_write. mem_read and mem_write both high is illegal; mem_write wins.
- Store forwarding: fwd = wb_reg_write & (wb_write_register==rt) & (rt!=0). Effective store data = fwd ? wb_write_data : store_data, evaluated in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, !mem_op:
  - stall=0.
  - MEM/WB loads the EX/MEM fields on the edge; memwb_read_data=0.
- IDLE, mem_op, alu_result[1:0]!=0:
  - No access; stall=0; misalign=1 this cycle.
  - MEM/WB loads with memwb_reg_write forced to 0.
- IDLE, mem_op, aligned:
  - stall=1 combinationally.
  - Latch addr, effective store data, we, and the destination/control fields; go to REQ.
  - MEM/WB loads a bubble (all 0).
- REQ:
  - dmem_req=1 with latched values; stall=1.
  - On gnt: store→DONE; load→WAIT.
- WAIT:
  - dmem_req=0; stall=1.
  - On rvalid: capture rdata; go to DONE.
  - rvalid in the same cycle as gnt (in REQ) is not legal for this port.
- DONE:
  - stall=0 for exactly one cycle.
  - MEM/WB loads the latched fields plus captured read data (store: read_data=0); go to IDLE.
  - Upstream advances on this same edge, so IDLE sees the next instruction.
- While stalling (REQ, WAIT), MEM/WB loads a bubble each edge.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT-1 without completion: bus_err=1 that cycle; dmem_req drops; go to DONE with memwb_reg_write=0 and read data 0.
  - A late rvalid or gnt arriving in IDLE or DONE is ignored.
- rst mid-access: the access is abandoned, no MEM/WB update, and the FSM restarts in IDLE.
- Load latency with gnt and rvalid each one cycle after the previous step is 3 stall cycles. A store with immediate gnt costs 2 stall cycles.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE/REQ/WAIT/DONE)
  - WORD_W=32, REG_W=5
  - a memwb_t struct typedef for the MEM/WB fields
- One natural sub-module: memwb_reg, the MEM/WB register with a bubble input and async reset.
- The forwarding compare stays inline.

Test Plan:
- ALU op, reg_write=1, write_register=5, alu_result=0x1234, no mem_op → stall never high; after 1 edge memwb_write_register=5, memwb_alu_result=0x1234, memwb_reg_write=1.
- Load at 0x40, gnt after 2 cycles, rvalid 1 cycle later with 0xDEADBEEF → dmem_addr=0x40, dmem_we=0; stall high exactly 4 cycles; memwb_read_data=0xDEADBEEF, memwb_mem_to_reg=1.
- Store, rt=7, store_data=0x11, with wb_reg_write=1, wb_write_register=7, wb_write_data=0x99 → dmem_wdata=0x99; repeat with rt=0 → dmem_wdata=0x11.
- Load at 0x42 → misalign pulses 1 cycle, dmem_req never asserts, memwb_reg_write=0, stall=0.
- Load with gnt never asserted, TIMEOUT=16 → bus_err pulse in the 16th stall cycle, then DONE, memwb_reg_write=0, stall drops.
- rst asserted during WAIT → dmem_req, stall, and all memwb_* outputs 0 immediately; a subsequent rvalid has no effect.
